// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the execute stage (ALU ops, forward selects, multiplier FSM).
package mips_pkg;
  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_NONE = 3'b011,
    ALU_MFLO = 3'b100,
    ALU_MFHI = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;
  typedef enum logic [1:0] {
    FWD_REG  = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_REG2 = 2'b11
  } fwd_e;
  typedef enum logic {
    MUL_IDLE,
    MUL_BUSY
  } mul_state_e;
endpackage

// File: rtl/mul_iter.sv
// mul_iter: iterative 32x32 unsigned shift-add multiplier; product register updates
// atomically on the 32nd step and otherwise holds its previous value.
module mul_iter
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [63:0] product
);
  mul_state_e state, state_n;
  logic [4:0] count;
  logic [31:0] mcand;
  logic [63:0] acc;
  logic [32:0] sum;
  logic last;
  // acc holds {partial high, remaining multiplier bits}; each step shifts right by one
  assign sum = {1'b0, acc[63:32]} + {1'b0, acc[0] ? mcand : 32'd0};
  assign last = state == MUL_BUSY && count == 5'd31;
  assign busy = state == MUL_BUSY;
  always_comb begin
    state_n = state;
    if (state == MUL_IDLE && start) state_n = MUL_BUSY;
    else if (last) state_n = MUL_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= MUL_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count   <= '0;
      mcand   <= '0;
      acc     <= '0;
      product <= '0;
    end else if (state == MUL_IDLE && start) begin
      count <= '0;
      mcand <= a;
      acc   <= {32'd0, b};
    end else if (state == MUL_BUSY) begin
      count <= count + 5'd1;
      acc   <= {sum, acc[31:1]};
      if (last) product <= {sum, acc[31:1]};
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with forwarding muxes, ALU and optional HI/LO multiplier.
// Multiplier, HI/LO and MFHI/MFLO exist only when MULT_UNIT_EN is defined.
module ex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  RdE,
  input  logic [31:0] SignImmE,
  input  logic        RegDstE,
  input  logic        ALUSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] ResultW,
  input  logic        MulStartE,
  output logic [31:0] ALUOutE,
  output logic [31:0] WriteDataE,
  output logic [4:0]  WriteRegE,
  output logic        ZeroE,
  output logic        MulBusyE,
  output logic        MulHazardE
);
  logic [31:0] src_a, src_b, hi, lo;
  logic unused_rs;
  assign unused_rs = ^RsE;
  assign src_a = ForwardAE == FWD_MEM ? ALUOutM : ForwardAE == FWD_WB ? ResultW : RD1E;
  assign WriteDataE = ForwardBE == FWD_MEM ? ALUOutM : ForwardBE == FWD_WB ? ResultW : RD2E;
  assign src_b = ALUSrcE ? SignImmE : WriteDataE;
  assign WriteRegE = RegDstE ? RdE : RtE;
`ifdef MULT_UNIT_EN
  logic [63:0] product;
  mul_iter u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (MulStartE),
    .a       (src_a),
    .b       (WriteDataE),
    .busy    (MulBusyE),
    .product (product)
  );
  assign {hi, lo} = product;
  assign MulHazardE = MulBusyE & (MulStartE | ALUControlE == ALU_MFLO | ALUControlE == ALU_MFHI);
`else
  logic unused_mul;
  assign unused_mul = ^{clk, rst_n, MulStartE};
  assign hi = '0;
  assign lo = '0;
  assign MulBusyE = 1'b0;
  assign MulHazardE = 1'b0;
`endif
  always_comb begin
    ALUOutE = '0;
    case (alu_op_e'(ALUControlE))
      ALU_ADD:  ALUOutE = src_a + src_b;
      ALU_SUB:  ALUOutE = src_a - src_b;
      ALU_AND:  ALUOutE = src_a & src_b;
      ALU_OR:   ALUOutE = src_a | src_b;
      ALU_SLT:  ALUOutE = {31'd0, $signed(src_a) < $signed(src_b)};
      ALU_MFLO: ALUOutE = lo;
      ALU_MFHI: ALUOutE = hi;
      default:  ALUOutE = '0;
    endcase
  end
  assign ZeroE = ALUOutE == 32'd0;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed + randomized checks of ex_stage against an arithmetic reference model.
module tb_ex_stage;
  logic        clk = 0, rst_n = 0;
  logic [31:0] RD1E = 0, RD2E = 0, SignImmE = 0, ALUOutM = 0, ResultW = 0;
  logic [4:0]  RsE = 0, RtE = 0, RdE = 0;
  logic        RegDstE = 0, ALUSrcE = 0, MulStartE = 0;
  logic [2:0]  ALUControlE = 3'b010;
  logic [1:0]  ForwardAE = 0, ForwardBE = 0;
  logic [31:0] ALUOutE, WriteDataE;
  logic [4:0]  WriteRegE;
  logic        ZeroE, MulBusyE, MulHazardE;
  int tests = 0, fails = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .RD1E(RD1E), .RD2E(RD2E), .RsE(RsE), .RtE(RtE), .RdE(RdE),
    .SignImmE(SignImmE), .RegDstE(RegDstE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUOutM(ALUOutM), .ResultW(ResultW),
    .MulStartE(MulStartE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
    .ZeroE(ZeroE), .MulBusyE(MulBusyE), .MulHazardE(MulHazardE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rd);
    if (sel == 2'b10) return ALUOutM;
    if (sel == 2'b01) return ResultW;
    return rd;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a; sb = b;
    case (op)
      3'b010: return a + b;
      3'b110: return a - b;
      3'b000: return a & b;
      3'b001: return a | b;
      3'b111: return (sa < sb) ? 32'd1 : 32'd0;
      3'b100: return m_lo;
      3'b101: return m_hi;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_comb(input string tag);
    logic [31:0] a, wd, b, exp;
    a = pick(ForwardAE, RD1E);
    wd = pick(ForwardBE, RD2E);
    b = ALUSrcE ? SignImmE : wd;
    exp = ref_alu(ALUControlE, a, b);
    check({tag, "_alu"}, {32'd0, ALUOutE}, {32'd0, exp});
    check({tag, "_zero"}, {63'd0, ZeroE}, {63'd0, exp == 0});
    check({tag, "_wd"}, {32'd0, WriteDataE}, {32'd0, wd});
    check({tag, "_wreg"}, {59'd0, WriteRegE}, {59'd0, RegDstE ? RdE : RtE});
  endtask

`ifdef MULT_UNIT_EN
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int restart_at);
    int cycles;
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    @(negedge clk);
    ForwardAE = 0; ForwardBE = 0; RD1E = a; RD2E = b; ALUControlE = 3'b010; MulStartE = 1;
    @(negedge clk);
    MulStartE = 0;
    cycles = 0;
    while (MulBusyE === 1'b1 && cycles < 40) begin
      cycles++;
      RD1E = $urandom; RD2E = $urandom;
      MulStartE = (cycles == restart_at);
      if (cycles == 2) begin
        ALUControlE = 3'b101;
        #1;
        check("mfhi_busy_hazard", {63'd0, MulHazardE}, 64'd1);
        check("mfhi_busy_old_hi", {32'd0, ALUOutE}, {32'd0, m_hi});
      end else if (cycles == 3) begin
        ALUControlE = 3'b010;
        #1;
        check("add_busy_nohazard", {63'd0, MulHazardE}, {63'd0, MulStartE});
      end
      @(negedge clk);
    end
    MulStartE = 0;
    check("mul_busy_cycles", cycles, 32);
    m_hi = prod[63:32]; m_lo = prod[31:0];
    ALUControlE = 3'b101; #1;
    check("mfhi_result", {32'd0, ALUOutE}, {32'd0, m_hi});
    ALUControlE = 3'b100; #1;
    check("mflo_result", {32'd0, ALUOutE}, {32'd0, m_lo});
    check("mul_idle_after", {63'd0, MulBusyE}, 64'd0);
  endtask
`endif

  initial begin
    #1;
    check("rst_busy", {63'd0, MulBusyE}, 64'd0);
    check("rst_hazard", {63'd0, MulHazardE}, 64'd0);
    ALUControlE = 3'b101; #1;
    check("rst_mfhi", {32'd0, ALUOutE}, 64'd0);
    ALUControlE = 3'b100; #1;
    check("rst_mflo", {32'd0, ALUOutE}, 64'd0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    RD1E = 5; RD2E = 7; ALUControlE = 3'b010; #1;
    check("add_5_7", {32'd0, ALUOutE}, 64'd12);
    check("add_5_7_zero", {63'd0, ZeroE}, 64'd0);
    RD2E = 5; ALUControlE = 3'b110; #1;
    check("sub_eq", {32'd0, ALUOutE}, 64'd0);
    check("sub_eq_zero", {63'd0, ZeroE}, 64'd1);
    ForwardAE = 2'b10; ALUOutM = 32'h100; ForwardBE = 2'b01; ResultW = 3; ALUControlE = 3'b001; #1;
    check("fwd_or", {32'd0, ALUOutE}, 64'h103);
    check("fwd_wd", {32'd0, WriteDataE}, 64'd3);
    ForwardAE = 0; ForwardBE = 0; RD1E = 32'hFFFFFFFF; RD2E = 1; ALUControlE = 3'b111;
    RegDstE = 1; RdE = 9; RtE = 4; #1;
    check("slt_neg", {32'd0, ALUOutE}, 64'd1);
    check("wreg_rd", {59'd0, WriteRegE}, 64'd9);
    ALUControlE = 3'b011; #1;
    check("op011", {32'd0, ALUOutE}, 64'd0);
    for (int i = 0; i < 40; i++) begin
      RD1E = $urandom; RD2E = (i % 5 == 0) ? RD1E : $urandom; SignImmE = $urandom;
      ALUOutM = $urandom; ResultW = $urandom;
      RtE = 5'($urandom); RdE = 5'($urandom); RsE = 5'($urandom);
      RegDstE = 1'($urandom); ALUSrcE = 1'($urandom);
      ALUControlE = 3'($urandom); ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      #1;
      check_comb("rand");
    end
    ALUSrcE = 0; ForwardAE = 0; ForwardBE = 0;
`ifdef MULT_UNIT_EN
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check("max_hi", {32'd0, m_hi}, 64'hFFFFFFFE);
    check("max_lo", {32'd0, m_lo}, 64'h00000001);
    run_mul(6, 7, 5);
    check("restart_ignored_lo", {32'd0, m_lo}, 64'd42);
    run_mul(0, 32'hFFFFFFFF, 0);
    for (int i = 0; i < 3; i++) run_mul($urandom, $urandom, 0);
    @(negedge clk);
    RD1E = 9; RD2E = 11; MulStartE = 1;
    @(negedge clk);
    MulStartE = 0;
    repeat (9) @(negedge clk);
    rst_n = 0; #1;
    m_hi = 0; m_lo = 0;
    check("midrst_busy", {63'd0, MulBusyE}, 64'd0);
    ALUControlE = 3'b101; #1;
    check("midrst_hi", {32'd0, ALUOutE}, 64'd0);
    ALUControlE = 3'b100; #1;
    check("midrst_lo", {32'd0, ALUOutE}, 64'd0);
    @(negedge clk); rst_n = 1;
    repeat (40) @(negedge clk);
    check("midrst_lo_stays", {32'd0, ALUOutE}, 64'd0);
`else
    @(negedge clk);
    RD1E = 6; RD2E = 7; MulStartE = 1;
    @(negedge clk);
    MulStartE = 0;
    for (int i = 0; i < 5; i++) begin
      ALUControlE = 3'b100; #1;
      check("nomul_busy", {63'd0, MulBusyE}, 64'd0);
      check("nomul_hazard", {63'd0, MulHazardE}, 64'd0);
      check("nomul_mflo", {32'd0, ALUOutE}, 64'd0);
      ALUControlE = 3'b101; #1;
      check("nomul_mfhi", {32'd0, ALUOutE}, 64'd0);
      @(negedge clk);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 rst_n  input  1  reset: asynchronous, active-low.
REQ-003 RD1E, RD2E  input  32 each  register operands from ID/EX.
REQ-004 RsE, RtE, RdE  input  5 each  register numbers.
REQ-005 SignImmE  input  32  sign-extended immediate.
REQ-006 RegDstE, ALUSrcE  input  1 each  dest select (1=Rd), SrcB select (1=imm).
REQ-007 ALUControlE  input  3  ALU op.
REQ-008 ForwardAE, ForwardBE  input  2 each  00=RDxE, 01=ResultW, 10=ALUOutM, 11=RDxE.
REQ-009 ALUOutM, ResultW  input  32 each  forwarding sources.
REQ-010 MulStartE  input  1  unsigned multiply request (multu).
REQ-011 ALUOutE  output  32  ALU/HI/LO result.
REQ-012 WriteDataE  output  32  forwarded SrcB before imm mux.
REQ-013 WriteRegE  output  5  RdE if RegDstE else RtE.
REQ-014 ZeroE  output  1  ALUOutE==0.
REQ-015 MulBusyE  output  1  multiplier iterating.
REQ-016 MulHazardE  output  1  stall request to hazard unit.

Function
REQ-017 SrcAE = forward mux A; SrcBE = ALUSrcE ? SignImmE : WriteDataE; all combinational.
REQ-018 ALUControlE: 010 add, 110 sub (mod 2^32, no overflow trap), 000 and, 001 or, 111 slt (signed, result 0/1), 100 MFLO (LO), 101 MFHI (HI), 011 -> 0.
REQ-019 Multiplier FSM states IDLE, BUSY; reset -> IDLE.
REQ-020 IDLE & MulStartE at edge k: capture SrcAE and WriteDataE (unsigned), count=0, -> BUSY.
REQ-021 BUSY: one shift-add step per edge; after 32nd step (edge k+32) write 64-bit product HI/LO atomically, -> IDLE.
REQ-022 MulBusyE=1 exactly in BUSY (32 cycles); HI/LO hold old values until edge k+32.
REQ-023 MulStartE while BUSY ignored (no restart, operands unchanged).
REQ-024 MulHazardE = MulBusyE & (MulStartE | ALUControlE==100 | ALUControlE==101); combinational.
REQ-025 MFHI/MFLO in cycle after edge k+32 return new product; back-to-back multu at edge k+32 accepted (IDLE that cycle? no: next edge k+33).
REQ-026 Operands 0 or 0xFFFFFFFF: product exact 64-bit unsigned; no saturation.

Reset
REQ-027 rst_n low: FSM IDLE, count 0, HI=LO=0, captured operands 0, MulBusyE=0; applies mid-multiply, product discarded.
REQ-028 Combinational outputs follow inputs during reset; MFHI/MFLO read 0.

Configuration
REQ-029 MULT_UNIT_EN defined: multiplier, HI/LO, MFHI/MFLO as above.
REQ-030 MULT_UNIT_EN undefined: no FSM/HI/LO, MulStartE ignored, MulBusyE=MulHazardE=0, ALUControlE 100/101 -> 0.

Structure
REQ-031 Shared package mips_pkg: ALUControl encodings, Forward select encodings, FSM state typedef.
REQ-032 One sub-module mul_iter (iterative 32x32 unsigned shift-add, start/busy/product); instantiated only under MULT_UNIT_EN.

Verification
REQ-033 RD1E=5, RD2E=7, ALUControlE=010, Forward=00 -> ALUOutE=12, ZeroE=0; 110 with equal operands -> 0, ZeroE=1.
REQ-034 ForwardAE=10 ALUOutM=0x100, ForwardBE=01 ResultW=3, ALUSrcE=0, op 001 -> ALUOutE=0x103, WriteDataE=3.
REQ-035 slt SrcA=0xFFFFFFFF, SrcB=1 -> ALUOutE=1; RegDstE=1 RdE=9 -> WriteRegE=9.
REQ-036 multu 0xFFFFFFFF x 0xFFFFFFFF -> MulBusyE 32 cycles, then HI=0xFFFFFFFE, LO=0x00000001; MFHI during BUSY -> MulHazardE=1.
REQ-037 multu 6x7, second MulStartE at busy cycle 5 -> ignored, LO=42 at edge k+32.
REQ-038 rst_n low at busy cycle 10 -> MulBusyE=0 immediately, HI=LO=0; build without MULT_UNIT_EN -> MulStartE no effect, op 100 -> 0.
